// File: rtl/sm_vcu_pkg.sv
// Shared definitions for the schoolRISCV command/response coprocessor:
// opcodes, FSM states, response bit positions and the LFSR step.
package sm_vcu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_WAIT = 4'd1;
  localparam logic [3:0] OP_KEYS = 4'd2;
  localparam logic [3:0] OP_LEDS = 4'd3;
  localparam logic [3:0] OP_RAND = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT
  } state_e;

  localparam int RSP_ACK  = 31;
  localparam int RSP_BUSY = 30;
  localparam int RSP_ERR  = 29;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback mask selecting taps 16,14,13,11 (bits 0,2,3,5 of the right-shifting register)
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sm_vcu_if.sv
// Register-file side port of the coprocessor: x31 read port and x30 write-back word.
interface sm_vcu_if;
  logic [4:0]  cmd_reg_addr;
  logic [31:0] cmd_reg_rdata;
  logic [31:0] vcu_reg_rdata;

  modport master (output cmd_reg_addr, output vcu_reg_rdata, input cmd_reg_rdata);
  modport slave  (input cmd_reg_addr, input vcu_reg_rdata, output cmd_reg_rdata);
endinterface

// File: rtl/sm_vcu_sync.sv
// Parameterized two-flop synchronizer for asynchronous inputs.
module sm_vcu_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sm_vcu_ctrl.sv
// Command/response coprocessor: polls x31, executes NOP/WAIT/KEYS/LEDS/RAND, answers in x30.
// Define SM_VCU_LFSR_EN to build the LFSR behind OP 4; otherwise OP 4 reports ERR.
module sm_vcu_ctrl
  import sm_vcu_pkg::*;
#(
  parameter int KEY_W = 4,
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  sm_vcu_if.master         bus,
  input  logic [KEY_W-1:0] keys,
  output logic [LED_W-1:0] leds
);

  state_e      state, state_nxt;
  logic        cmd_req_q;
  logic [3:0]  cmd_op_q;
  logic [15:0] cmd_arg_q;
  logic        primed, armed, last_req;
  logic [3:0]  op_r;
  logic [15:0] arg_r;
  logic [15:0] cnt;
  logic [31:0] resp;
  logic [KEY_W-1:0] keys_s;

  logic        accept, complete, cnt_load, led_we, lfsr_adv, err_c;
  logic [23:0] result_c;
  logic        unused_cmd_bits;

  assign bus.cmd_reg_addr  = 5'd31;
  assign bus.vcu_reg_rdata = resp;
  assign unused_cmd_bits   = ^{bus.cmd_reg_rdata[30:28], bus.cmd_reg_rdata[23:16]};

  sm_vcu_sync #(.W(KEY_W)) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (keys),
    .q   (keys_s)
  );

`ifdef SM_VCU_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lfsr <= LFSR_SEED;
    else if (lfsr_adv) lfsr <= lfsr_step(lfsr);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    cnt_load  = 1'b0;
    led_we    = 1'b0;
    lfsr_adv  = 1'b0;
    err_c     = 1'b0;
    result_c  = '0;
    case (state)
      ST_IDLE: begin
        if (armed && (cmd_req_q != last_req)) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_NOP: complete = 1'b1;
          OP_WAIT: begin
            if (arg_r > 16'd1) begin
              cnt_load  = 1'b1;
              state_nxt = ST_WAIT;
            end else begin
              complete = 1'b1;
              result_c = {8'd0, arg_r};
            end
          end
          OP_KEYS: begin
            complete = 1'b1;
            result_c = 24'(keys_s);
          end
          OP_LEDS: begin
            complete = 1'b1;
            led_we   = 1'b1;
            result_c = 24'(leds);
          end
`ifdef SM_VCU_LFSR_EN
          OP_RAND: begin
            complete = 1'b1;
            lfsr_adv = 1'b1;
            result_c = {8'd0, lfsr_step(lfsr)};
          end
`endif
          default: begin
            complete = 1'b1;
            err_c    = 1'b1;
          end
        endcase
        if (complete) state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        // Counter hits zero on this edge
        if (cnt == 16'd1) begin
          complete  = 1'b1;
          result_c  = {8'd0, arg_r};
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command sampling, arming and response word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_req_q <= 1'b0;
      cmd_op_q  <= '0;
      cmd_arg_q <= '0;
      primed    <= 1'b0;
      armed     <= 1'b0;
      last_req  <= 1'b0;
      resp      <= '0;
      leds      <= '0;
    end else begin
      cmd_req_q <= bus.cmd_reg_rdata[31];
      cmd_op_q  <= bus.cmd_reg_rdata[27:24];
      cmd_arg_q <= bus.cmd_reg_rdata[15:0];
      primed    <= 1'b1;
      // First real sample of x31 after reset defines the idle REQ level
      if (primed && !armed) begin
        armed    <= 1'b1;
        last_req <= cmd_req_q;
      end
      if (accept) begin
        last_req       <= cmd_req_q;
        resp[RSP_BUSY] <= 1'b1;
      end
      if (complete) resp <= {last_req, 1'b0, err_c, 1'b0, op_r, result_c};
      if (led_we)   leds <= arg_r[LED_W-1:0];
    end
  end

  // Latched operation and wait counter
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= cmd_op_q;
      arg_r <= cmd_arg_q;
    end
    if (cnt_load)              cnt <= arg_r - 16'd1;
    else if (state == ST_WAIT) cnt <= cnt - 16'd1;
  end

endmodule

// File: tb/tb_sm_vcu_ctrl.sv
// Scoreboard bench for sm_vcu_ctrl: directed commands, queued expected responses, monitor on BUSY fall.
module tb_sm_vcu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = 4'h0;
  logic [7:0] leds;

  sm_vcu_if bus();

  sm_vcu_ctrl #(.KEY_W(4), .LED_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .keys (keys),
    .leds (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: every BUSY 1->0 transition outside reset is a completion
  initial begin
    logic [31:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) prev = '0;
      else begin
        if (prev[30] && !bus.vcu_reg_rdata[30]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got %h expected no completion", bus.vcu_reg_rdata);
          end else begin
            check("sb_resp", bus.vcu_reg_rdata, exp_q.pop_front());
          end
        end
        prev = bus.vcu_reg_rdata;
      end
    end
  end

  task automatic send(input logic [31:0] cmd);
    @(posedge clk);
    #1 bus.cmd_reg_rdata = cmd;
  endtask

  task automatic send_exp(input logic [31:0] cmd, input logic [31:0] exp);
    exp_q.push_back(exp);
    send(cmd);
  endtask

  // k counts negedges from the cycle the command was driven (k=0 is C0)
  task automatic wait_done(input logic req, output int busy_k, output int done_k);
    busy_k = -1;
    done_k = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy_k < 0 && bus.vcu_reg_rdata[30]) busy_k = k;
      if (busy_k >= 0 && !bus.vcu_reg_rdata[30] && bus.vcu_reg_rdata[31] == req) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) begin
      n_checks++;
      $display("FAIL timeout: got no completion expected ack %0d", req);
    end
  endtask

  initial begin
    int b, d;
    logic [31:0] rand_exp;
    bus.cmd_reg_rdata = 32'h8000_0000;
    keys = 4'h9;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp", bus.vcu_reg_rdata, 32'h0);
    check("rst_leds", {24'd0, leds}, 32'h0);
    check("cmd_addr", {27'd0, bus.cmd_reg_addr}, 32'd31);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(negedge clk);
    check("arm_no_fire", bus.vcu_reg_rdata, 32'h0);

    send_exp(32'h0300_00A5, 32'h0300_0000);
    wait_done(1'b0, b, d);
    check("leds_busy_c2", b, 2);
    check("leds_ack_c3", d, 3);
    check("leds_a5", {24'd0, leds}, 32'h0000_00A5);

    send_exp(32'h8000_0000, 32'h8000_0000);
    wait_done(1'b1, b, d);
    check("nop_ack_c3", d, 3);

    send_exp(32'h0100_000A, 32'h0100_000A);
    wait_done(1'b0, b, d);
    check("wait_busy_c2", b, 2);
    check("wait_ack_c12", d, 12);

    send_exp(32'h8100_000A, 32'h8100_000A);
    repeat (4) @(posedge clk);
    send_exp(32'h0200_0000, 32'h0200_0009);
    wait_done(1'b1, b, d);
    check("ovl_wait_busy_cleared", {31'd0, bus.vcu_reg_rdata[30]}, 32'd0);
    wait_done(1'b0, b, d);
    check("ovl_keys_resp", bus.vcu_reg_rdata, 32'h0200_0009);

    send_exp(32'h8700_1234, 32'hA700_0000);
    wait_done(1'b1, b, d);
    check("illegal_ack_c3", d, 3);

`ifdef SM_VCU_LFSR_EN
    rand_exp = 32'h0400_5670;
`else
    rand_exp = 32'h2400_0000;
`endif
    send_exp(32'h0400_0000, rand_exp);
    wait_done(1'b0, b, d);
    check("rand_ack_c3", d, 3);

    send_exp(32'h8300_003C, 32'h8300_00A5);
    wait_done(1'b1, b, d);
    check("leds_3c", {24'd0, leds}, 32'h0000_003C);

    send(32'h0100_0014);
    repeat (6) @(posedge clk);
    check("abort_busy", {31'd0, bus.vcu_reg_rdata[30]}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("abort_resp", bus.vcu_reg_rdata, 32'h0);
    check("abort_leds", {24'd0, leds}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rearm_no_fire", bus.vcu_reg_rdata, 32'h0);

    send_exp(32'h8000_0000, 32'h8000_0000);
    wait_done(1'b1, b, d);
    check("rearm_nop_c3", d, 3);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
